// File: rtl/ws2812_receiver_pkg.sv
// Shared types and default timing for the WS2812 receiver.
package ws2812_receiver_pkg;

    // Line-decoder states.
    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,  // waiting for a full reset gap before trusting the line
        ST_WAIT_HIGH = 2'd1,  // gap seen; the next rising edge starts a frame
        ST_HIGH      = 2'd2,  // measuring a high pulse
        ST_LOW       = 2'd3   // measuring the low time after a bit
    } state_e;

    // Default timing in clock cycles (100 MHz: T0H=40, T1H=80, reset gap 50 us).
    localparam int DEF_BIT_THRESHOLD = 60;
    localparam int DEF_MIN_HIGH      = 10;
    localparam int DEF_MAX_HIGH      = 120;
    localparam int DEF_RESET_CYCLES  = 5000;

    // Bits per LED word (G, R, B octets).
    localparam int GRB_WIDTH = 24;

endpackage

// File: rtl/ws2812_line_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus a third
// flop holding the previous synchronized value for edge detection.
module ws2812_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Shift the raw line through the synchronizer and edge-detect stage.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], line_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  =  sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 serial-line receiver: decodes pulse widths into 24-bit GRB words
// and writes them through a memory write port at consecutive addresses.
module ws2812_receiver
    import ws2812_receiver_pkg::*;
#(
    parameter int DATAWIDTH     = 32,
    parameter int ADDRESSWIDTH  = 6,
    parameter int BIT_THRESHOLD = DEF_BIT_THRESHOLD,
    parameter int MIN_HIGH      = DEF_MIN_HIGH,
    parameter int MAX_HIGH      = DEF_MAX_HIGH,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES
) (
    input  logic                    iSIGNAL_CLOCK,
    input  logic                    iRESET,
    input  logic                    iCTRL_IN,
    input  logic                    iENABLE,
    input  logic [ADDRESSWIDTH-1:0] rSTART_ADDRESS,
    input  logic [15:0]             iNUM_LEDS,
    output logic                    oWriteEn,
    output logic [ADDRESSWIDTH-1:0] oWriteAddress,
    output logic [DATAWIDTH-1:0]    oDataOut,
    output logic                    oFrameDone,
    output logic [15:0]             oLedCount,
    output logic                    oError
);

    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam int BW = $clog2(GRB_WIDTH + 1);

    localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HIGH_ONE = HW'(BIT_THRESHOLD);
    localparam logic [HW-1:0] HIGH_MAX = HW'(MAX_HIGH);
    localparam logic [LW-1:0] LOW_GAP  = LW'(RESET_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(GRB_WIDTH - 1);

    logic line_level, line_rise, line_fall;

    state_e                  state_q,   state_d;
    logic [HW-1:0]           high_cnt_q, high_cnt_d;
    logic [LW-1:0]           low_cnt_q,  low_cnt_d;
    logic [GRB_WIDTH-1:0]    shift_q,    shift_d;
    logic [BW-1:0]           bit_cnt_q,  bit_cnt_d;
    logic [ADDRESSWIDTH-1:0] start_q,    start_d;
    logic [15:0]             num_q,      num_d;
    logic                    we_q,       we_d;
    logic [ADDRESSWIDTH-1:0] addr_q,     addr_d;
    logic [DATAWIDTH-1:0]    data_q,     data_d;
    logic                    done_q,     done_d;
    logic [15:0]             led_cnt_q,  led_cnt_d;
    logic                    err_q,      err_d;

    logic bit_valid, bit_val, err_set;

    ws2812_line_sync u_line_sync (
        .clk_i   (iSIGNAL_CLOCK),
        .rst_i   (iRESET),
        .line_i  (iCTRL_IN),
        .level_o (line_level),
        .rise_o  (line_rise),
        .fall_o  (line_fall)
    );

    // Next-state, pulse measurement, bit assembly and write generation.
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        start_d    = start_q;
        num_d      = num_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        led_cnt_d  = led_cnt_q;
        err_d      = err_q;
        bit_valid  = 1'b0;
        bit_val    = 1'b0;
        err_set    = 1'b0;

        if (!iENABLE) begin
            // Disabled: drop any partial word and demand a fresh gap.
            state_d   = ST_SYNC;
            low_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_SYNC: begin
                    if (line_level) begin
                        low_cnt_d = '0;
                    end else if (low_cnt_q >= LOW_GAP) begin
                        state_d   = ST_WAIT_HIGH;
                        low_cnt_d = '0;
                    end else begin
                        low_cnt_d = low_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (line_rise) begin
                        // First rising edge of a frame: restart bookkeeping.
                        state_d    = ST_HIGH;
                        high_cnt_d = HW'(1);  // the edge cycle is the first high cycle
                        bit_cnt_d  = '0;
                        led_cnt_d  = '0;
                        err_d      = 1'b0;
                        start_d    = rSTART_ADDRESS;
                        num_d      = iNUM_LEDS;
                    end
                end

                ST_HIGH: begin
                    if (line_fall) begin
                        state_d   = ST_LOW;
                        low_cnt_d = LW'(1);  // the edge cycle is the first low cycle
                        if (high_cnt_q < HIGH_MIN) begin
                            err_set = 1'b1;
                        end else begin
                            bit_valid = 1'b1;
                            bit_val   = (high_cnt_q >= HIGH_ONE);
                        end
                    end else if (high_cnt_q >= HIGH_MAX) begin
                        state_d   = ST_SYNC;
                        low_cnt_d = '0;
                        bit_cnt_d = '0;
                        err_set   = 1'b1;
                    end else if (high_cnt_q != '1) begin
                        high_cnt_d = high_cnt_q + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (line_rise) begin
                        state_d    = ST_HIGH;
                        high_cnt_d = HW'(1);
                    end else if (low_cnt_q >= LOW_GAP) begin
                        state_d   = ST_WAIT_HIGH;
                        low_cnt_d = '0;
                        done_d    = 1'b1;
                        err_set   = (bit_cnt_q != '0);
                        bit_cnt_d = '0;
                    end else if (low_cnt_q != '1) begin
                        low_cnt_d = low_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        if (bit_valid) begin
            shift_d = {shift_q[GRB_WIDTH-2:0], bit_val};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                // Words beyond the requested count are decoded but not stored.
                if (led_cnt_q < num_q) begin
                    we_d                   = 1'b1;
                    addr_d                 = start_q + led_cnt_q[ADDRESSWIDTH-1:0];
                    data_d                 = '0;
                    data_d[GRB_WIDTH-1:0]  = shift_d;
                    led_cnt_d              = led_cnt_q + 16'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // A new error outranks the frame-start clear above.
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge iSIGNAL_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q    <= ST_SYNC;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            start_q    <= '0;
            num_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            led_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            start_q    <= start_d;
            num_q      <= num_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            led_cnt_q  <= led_cnt_d;
            err_q      <= err_d;
        end
    end

    assign oWriteEn      = we_q;
    assign oWriteAddress = addr_q;
    assign oDataOut      = data_q;
    assign oFrameDone    = done_q;
    assign oLedCount     = led_cnt_q;
    assign oError        = err_q;

endmodule

// File: doc/ws2812_receiver.md
WS2812_RECEIVER -- requirements
Module: ws2812_receiver

Interface
REQ-001 Parameters SHALL be, one per line:
- DATAWIDTH, 32: memory word width.
- ADDRESSWIDTH, 6: write address width.
- BIT_THRESHOLD, 60: high-pulse cycles at or above which a bit decodes as 1 (100 MHz: T0H=40, T1H=80).
- MIN_HIGH, 10: shorter high pulses are glitches.
- MAX_HIGH, 120: longer high pulses are protocol errors.
- RESET_CYCLES, 5000: low time that ends a frame (50 us).
REQ-002 Ports SHALL be: name, direction, width, meaning.
- iSIGNAL_CLOCK, in, 1: the block's one clock.
- iRESET, in, 1: reset, asynchronous and active-high.
- iCTRL_IN, in, 1: asynchronous WS2812 serial line.
- iENABLE, in, 1: capture enable.
- rSTART_ADDRESS, in, ADDRESSWIDTH: first word address.
- iNUM_LEDS, in, 16: number of words to capture per frame.
- oWriteEn, out, 1: one-cycle memory write strobe.
- oWriteAddress, out, ADDRESSWIDTH: write address.
- oDataOut, out, DATAWIDTH: [31:24]=0; [23:0]=GRB word, first received bit in [23].
- oFrameDone, out, 1: one-cycle end-of-frame pulse.
- oLedCount, out, 16: words captured in the current or last frame.
- oError, out, 1: sticky protocol error flag.

Function
REQ-003 iCTRL_IN SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value and its registered copy for edge detection.
REQ-004 FSM states SHALL be SYNC, WAIT_HIGH, HIGH and LOW.
REQ-005 SYNC SHALL count consecutive low cycles and go to WAIT_HIGH after RESET_CYCLES; a high resets the count.
REQ-006 WAIT_HIGH SHALL go to HIGH on a rising edge and clear the high counter; it SHALL stay there indefinitely otherwise.
REQ-007 HIGH SHALL count cycles; on a falling edge with count >= MIN_HIGH, it SHALL shift in the bit (1 iff count >= BIT_THRESHOLD) and go to LOW.
REQ-008 A falling edge in HIGH with count < MIN_HIGH SHALL set oError, drop the pulse and go to LOW.
REQ-009 Count reaching MAX_HIGH in HIGH SHALL set oError, discard the partial word and go to SYNC.
REQ-010 LOW SHALL count low cycles. A rising edge SHALL go to HIGH. Reaching RESET_CYCLES SHALL end the frame and go to WAIT_HIGH.
REQ-011 After the 24th bit of a word, oWriteEn SHALL be high for exactly one cycle, on the cycle after the falling edge that completed the bit. oDataOut and oWriteAddress SHALL be valid in that same cycle.
REQ-012 oWriteAddress SHALL equal (rSTART_ADDRESS + word index) modulo 2^ADDRESSWIDTH, wrapping silently.
REQ-013 Once oLedCount == iNUM_LEDS, later bits SHALL be decoded but not written, and no error SHALL be raised. iNUM_LEDS == 0 SHALL suppress all writes.
REQ-014 At frame end, oFrameDone SHALL pulse for one cycle.
REQ-015 A frame ending with a nonzero partial bit count SHALL set oError; the partial word SHALL be discarded and not written.
REQ-016 oLedCount SHALL clear on the first rising edge of a new frame, increment on each write, and hold after oFrameDone.
REQ-017 oError SHALL clear only on reset or on the first rising edge of a new frame. If the clear and a new set happen in the same cycle, the set SHALL win.
REQ-018 iENABLE low SHALL force SYNC and suppress oWriteEn and oFrameDone. Raising iENABLE SHALL require a full reset gap before any capture.
REQ-019 rSTART_ADDRESS and iNUM_LEDS SHALL be sampled on the first rising edge of each frame.
REQ-020 All counters SHALL saturate and never wrap.

Reset
REQ-021 iRESET SHALL asynchronously force:
- state SYNC;
- all counters, the shift register and synchronizer flops to 0;
- oWriteEn=0, oFrameDone=0, oError=0, oLedCount=0, oDataOut=0, oWriteAddress=0.
REQ-022 Reset asserted mid-word SHALL discard the word with no write. After release, the block SHALL require a full reset gap before decoding.

Structure
REQ-023 A shared package SHALL hold:
- the FSM state enum;
- the default timing constants (BIT_THRESHOLD, MIN_HIGH, MAX_HIGH, RESET_CYCLES);
- the GRB field width constant (24).
REQ-024 The 2-flop synchronizer with edge detect SHALL be a sub-module named ws2812_line_sync.
REQ-025 The RTL SHALL be single-clock with no memory instantiation. The block writes through the existing simple dual-port memory's write port.

Verification
REQ-026 Reset gap, then 24 bits encoding 0x00FF00 (T0H=40/T0L=85, T1H=80/T1L=45), then 6000 low cycles -> exactly one write, oDataOut=0x0000FF00 at oWriteAddress=rSTART_ADDRESS, then one oFrameDone, oLedCount=1, oError=0.
REQ-027 iNUM_LEDS=3, rSTART_ADDRESS=62, ADDRESSWIDTH=6, five words sent -> writes at addresses 62, 63, 0 only; oLedCount=3; oError=0.
REQ-028 One 5-cycle high glitch between valid bits, and separately a 200-cycle high pulse -> oError=1 in each case; the glitch does not corrupt the next word, and the long pulse causes no write until a new gap.
REQ-029 Frame ending after 30 bits -> one write for the first word, no write for the 6-bit partial, oFrameDone=1, oError=1; the next frame's first rising edge clears oError.
REQ-030 iRESET asserted at bit 12 of a word, then released -> no write; a valid frame after a 5000-cycle gap is captured correctly.
REQ-031 Loopback of the existing WS2812 transmitter output with 8 LEDs of known data -> all 8 words reproduced at consecutive addresses.
